// File: rtl/training_sequencer_pkg.sv
// Shared types and defaults for the training sequencer and its benches.
package training_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_STEP,
        S_WAIT,
        S_ADVANCE,
        S_DONE
    } seq_state_t;

    localparam int EPOCHS_DEFAULT    = 100;
    localparam int SIZE_OF_X_DEFAULT = 2048;

endpackage

// File: rtl/training_sequencer_addr_counter.sv
// Sample address / epoch wrap counter with last-sample and last-epoch flags.
module sample_addr_counter
    import training_sequencer_pkg::*;
#(
    parameter int EPOCHS    = EPOCHS_DEFAULT,
    parameter int SIZE_OF_X = SIZE_OF_X_DEFAULT,
    parameter int ADDR_W    = 32,
    parameter int EPOCH_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               adv,
    output logic [ADDR_W-1:0]  address,
    output logic [EPOCH_W-1:0] epoch,
    output logic               last_sample,
    output logic               last_epoch
);

    localparam logic [ADDR_W-1:0]  ADDR_LAST  = ADDR_W'(SIZE_OF_X - 1);
    localparam logic [EPOCH_W-1:0] EPOCH_LAST = EPOCH_W'(EPOCHS - 1);

    assign last_sample = (address == ADDR_LAST);
    assign last_epoch  = (epoch == EPOCH_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            address <= '0;
            epoch   <= '0;
        end else if (clr) begin
            address <= '0;
            epoch   <= '0;
        end else if (adv) begin
            if (last_sample) begin
                address <= '0;
                // Never step past the final epoch even if asked to.
                if (!last_epoch)
                    epoch <= epoch + EPOCH_W'(1);
            end else begin
                address <= address + ADDR_W'(1);
            end
        end
    end

endmodule

// File: rtl/training_sequencer.sv
// Per-sample fetch / step / wait sequencer for network training over EPOCHS passes.
// Optional TRAIN_SEQ_CYCLE_CNT_EN adds a saturating busy-cycle counter output.
module training_sequencer
    import training_sequencer_pkg::*;
#(
    parameter int EPOCHS    = EPOCHS_DEFAULT,
    parameter int SIZE_OF_X = SIZE_OF_X_DEFAULT,
    parameter int ADDR_W    = 32,
    parameter int RD_LAT    = 1,
    parameter int EPOCH_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    output logic [ADDR_W-1:0]  address,
    output logic               bram_en,
    output logic               net_start,
    input  logic               net_done,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic [EPOCH_W-1:0] epoch
`ifdef TRAIN_SEQ_CYCLE_CNT_EN
    ,
    output logic [31:0]        cycle_count
`endif
);

    localparam logic [1:0] LAT_LAST = 2'(RD_LAT);

    seq_state_t state;
    logic [1:0] lat;
    logic       cnt_clr;
    logic       cnt_adv;
    logic       last_sample;
    logic       last_epoch;
    logic       run_end;

    assign run_end = abort || (last_sample && last_epoch);
    assign cnt_clr = (state == S_IDLE) && start;
    assign cnt_adv = (state == S_ADVANCE) && !run_end;

    sample_addr_counter #(
        .EPOCHS    (EPOCHS),
        .SIZE_OF_X (SIZE_OF_X),
        .ADDR_W    (ADDR_W),
        .EPOCH_W   (EPOCH_W)
    ) u_addr_counter (
        .clk         (clk),
        .reset       (reset),
        .clr         (cnt_clr),
        .adv         (cnt_adv),
        .address     (address),
        .epoch       (epoch),
        .last_sample (last_sample),
        .last_epoch  (last_epoch)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            lat       <= '0;
            bram_en   <= 1'b0;
            net_start <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            bram_en   <= 1'b0;
            net_start <= 1'b0;
            done      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_FETCH;
                        bram_en <= 1'b1;
                        lat     <= '0;
                        busy    <= 1'b1;
                        aborted <= 1'b0;
                    end
                end
                // First FETCH cycle issues the read, then RD_LAT cycles of read latency.
                S_FETCH: begin
                    if (lat == LAT_LAST) begin
                        state     <= S_STEP;
                        net_start <= 1'b1;
                    end else begin
                        lat <= lat + 2'd1;
                    end
                end
                S_STEP: state <= S_WAIT;
                S_WAIT: begin
                    if (net_done)
                        state <= S_ADVANCE;
                end
                S_ADVANCE: begin
                    if (run_end) begin
                        state   <= S_DONE;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        aborted <= abort;
                    end else begin
                        state   <= S_FETCH;
                        bram_en <= 1'b1;
                        lat     <= '0;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef TRAIN_SEQ_CYCLE_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cycle_count <= '0;
        else if (cnt_clr)
            cycle_count <= '0;
        else if (busy)
            cycle_count <= sat_inc(cycle_count);
    end
`endif

endmodule

// File: tb/tb_training_sequencer.sv
// Directed bench for training_sequencer: EPOCHS=2, SIZE_OF_X=4, RD_LAT=1, 3-cycle network step.
module tb_training_sequencer;

    localparam int EPOCHS    = 2;
    localparam int SIZE_OF_X = 4;
    localparam int ADDR_W    = 32;
    localparam int RD_LAT    = 1;
    localparam int EPOCH_W   = 16;

    logic               clk;
    logic               reset;
    logic               start;
    logic               abort;
    logic [ADDR_W-1:0]  address;
    logic               bram_en;
    logic               net_start;
    logic               net_done;
    logic               busy;
    logic               done;
    logic               aborted;
    logic [EPOCH_W-1:0] epoch;
`ifdef TRAIN_SEQ_CYCLE_CNT_EN
    logic [31:0]        cycle_count;
`endif

    logic model_done;
    logic inj_done;
    assign net_done = model_done | inj_done;

    int total;
    int bad;

    logic [ADDR_W-1:0]  log_addr [0:255];
    logic [EPOCH_W-1:0] log_ep   [0:255];
    int ns_total;
    int busy_total;
    int done_total;
    int base_ns;
    int base_busy;
    int base_done;

    training_sequencer #(
        .EPOCHS    (EPOCHS),
        .SIZE_OF_X (SIZE_OF_X),
        .ADDR_W    (ADDR_W),
        .RD_LAT    (RD_LAT),
        .EPOCH_W   (EPOCH_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .address   (address),
        .bram_en   (bram_en),
        .net_start (net_start),
        .net_done  (net_done),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .epoch     (epoch)
`ifdef TRAIN_SEQ_CYCLE_CNT_EN
        ,
        .cycle_count (cycle_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Network model: net_done pulses 3 cycles after each observed net_start.
    initial begin
        int cnt;
        cnt = 0;
        model_done = 1'b0;
        forever begin
            @(negedge clk);
            model_done = 1'b0;
            if (cnt > 0) begin
                cnt = cnt - 1;
                if (cnt == 0)
                    model_done = 1'b1;
            end
            if (net_start)
                cnt = 3;
        end
    end

    // Activity monitor: logs address/epoch per issued step and counts busy/done cycles.
    initial begin
        ns_total = 0;
        busy_total = 0;
        done_total = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (net_start) begin
                    if (ns_total < 256) begin
                        log_addr[ns_total] = address;
                        log_ep[ns_total]   = epoch;
                    end
                    ns_total = ns_total + 1;
                end
                if (busy) busy_total = busy_total + 1;
                if (done) done_total = done_total + 1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic take_base();
        base_ns   = ns_total;
        base_busy = busy_total;
        base_done = done_total;
    endtask

    task automatic start_pulse();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output bit seen);
        int n;
        n = 0;
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
        end
        seen = done;
    endtask

    task automatic wait_step(input logic [ADDR_W-1:0] a, input logic [EPOCH_W-1:0] e, output bit seen);
        int n;
        n = 0;
        while (!(net_start && address == a && epoch == e) && n < 400) begin
            @(negedge clk);
            n++;
        end
        seen = net_start && address == a && epoch == e;
    endtask

    task automatic test_reset();
        total++;
        if (address !== '0) begin bad++; $display("FAIL reset_address: got %0h want 0", address); end
        total++;
        if (epoch !== '0) begin bad++; $display("FAIL reset_epoch: got %0h want 0", epoch); end
        total++;
        if ({bram_en, net_start, busy, done, aborted} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 00000", {bram_en, net_start, busy, done, aborted});
        end
    endtask

    task automatic test_idle_net_done();
        @(negedge clk);
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, bram_en, net_start, done} !== 4'b0) begin
            bad++;
            $display("FAIL idle_net_done: got %b want 0000", {busy, bram_en, net_start, done});
        end
    endtask

    task automatic test_first_timing();
        bit err;
        take_base();
        start_pulse();
        // cycle 1 after start
        total++;
        if ({bram_en, busy, net_start} !== 3'b110 || address !== '0) begin
            bad++;
            $display("FAIL t_cycle1: got en/busy/ns=%b addr=%0h want 110 addr=0", {bram_en, busy, net_start}, address);
        end
        @(negedge clk);
        total++;
        if ({bram_en, net_start} !== 2'b00) begin
            bad++;
            $display("FAIL t_cycle2: got en/ns=%b want 00", {bram_en, net_start});
        end
        @(negedge clk);
        total++;
        if (net_start !== 1'b1 || address !== '0 || epoch !== '0) begin
            bad++;
            $display("FAIL t_cycle3_net_start: got ns=%b addr=%0h ep=%0h want 1 0 0", net_start, address, epoch);
        end
        err = 1'b0;
        for (int c = 4; c <= 7; c++) begin
            @(negedge clk);
            if (address !== '0 || net_start !== 1'b0 || bram_en !== 1'b0) err = 1'b1;
        end
        total++;
        if (err) begin bad++; $display("FAIL t_addr_hold: got change in cycles 4-7 want addr 0 held, en/ns 0"); end
        @(negedge clk);
        total++;
        if (address !== 32'd1 || bram_en !== 1'b1) begin
            bad++;
            $display("FAIL t_cycle8_fetch: got addr=%0h en=%b want 1 1", address, bram_en);
        end
    endtask

    task automatic test_full_run();
        bit seen;
        wait_done(seen);
        total++;
        if (!seen) begin bad++; $display("FAIL run_done_timeout: got no done want done"); end
        repeat (4) @(negedge clk);
        total++;
        if (ns_total - base_ns !== 8) begin bad++; $display("FAIL run_steps: got %0d want 8", ns_total - base_ns); end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (log_addr[base_ns + i] !== ADDR_W'(i % 4) || log_ep[base_ns + i] !== EPOCH_W'(i / 4)) begin
                bad++;
                $display("FAIL run_sample%0d: got addr=%0h ep=%0h want addr=%0h ep=%0h",
                         i, log_addr[base_ns + i], log_ep[base_ns + i], i % 4, i / 4);
            end
        end
        total++;
        if (done_total - base_done !== 1) begin bad++; $display("FAIL run_done_count: got %0d want 1", done_total - base_done); end
        total++;
        if (busy_total - base_busy !== 56) begin bad++; $display("FAIL run_busy_cycles: got %0d want 56", busy_total - base_busy); end
        total++;
        if (aborted !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL run_flags: got aborted=%b busy=%b want 0 0", aborted, busy); end
        total++;
        if (address !== 32'd3 || epoch !== 16'd1) begin
            bad++;
            $display("FAIL run_final_hold: got addr=%0h ep=%0h want 3 1", address, epoch);
        end
`ifdef TRAIN_SEQ_CYCLE_CNT_EN
        total++;
        if (cycle_count !== 32'd56) begin bad++; $display("FAIL cycle_count: got %0d want 56", cycle_count); end
        repeat (5) @(negedge clk);
        total++;
        if (cycle_count !== 32'd56) begin bad++; $display("FAIL cycle_count_hold: got %0d want 56", cycle_count); end
`endif
    endtask

    task automatic test_abort();
        bit seen;
        take_base();
        start_pulse();
        wait_step(32'd2, 16'd0, seen);
        total++;
        if (!seen) begin bad++; $display("FAIL abort_find_sample2: got none want net_start at addr 2"); end
        abort = 1'b1;
        wait_done(seen);
        abort = 1'b0;
        total++;
        if (!seen) begin bad++; $display("FAIL abort_done_timeout: got no done want done"); end
        repeat (8) @(negedge clk);
        total++;
        if (ns_total - base_ns !== 3) begin bad++; $display("FAIL abort_steps: got %0d want 3", ns_total - base_ns); end
        total++;
        if (aborted !== 1'b1) begin bad++; $display("FAIL abort_flag: got %b want 1", aborted); end
        total++;
        if (address !== 32'd2 || epoch !== 16'd0) begin
            bad++;
            $display("FAIL abort_hold: got addr=%0h ep=%0h want 2 0", address, epoch);
        end
        total++;
        if (done_total - base_done !== 1) begin bad++; $display("FAIL abort_done_count: got %0d want 1", done_total - base_done); end
    endtask

    task automatic test_start_while_busy();
        bit seen;
        bit err;
        take_base();
        start_pulse();
        total++;
        if (aborted !== 1'b0) begin bad++; $display("FAIL restart_clears_aborted: got %b want 0", aborted); end
        repeat (10) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(seen);
        total++;
        if (!seen) begin bad++; $display("FAIL busy_start_done_timeout: got no done want done"); end
        repeat (4) @(negedge clk);
        total++;
        if (ns_total - base_ns !== 8) begin bad++; $display("FAIL busy_start_steps: got %0d want 8", ns_total - base_ns); end
        err = 1'b0;
        for (int i = 0; i < 8; i++)
            if (log_addr[base_ns + i] !== ADDR_W'(i % 4) || log_ep[base_ns + i] !== EPOCH_W'(i / 4)) err = 1'b1;
        total++;
        if (err) begin bad++; $display("FAIL busy_start_seq: got wrong address/epoch sequence want 0..3 x2"); end
        total++;
        if (busy_total - base_busy !== 56) begin bad++; $display("FAIL busy_start_cycles: got %0d want 56", busy_total - base_busy); end
    endtask

    task automatic test_reset_mid_run();
        bit seen;
        start_pulse();
        wait_step(32'd2, 16'd1, seen);
        total++;
        if (!seen) begin bad++; $display("FAIL rst_find_step: got none want net_start at addr 2 ep 1"); end
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        total++;
        if (address !== '0 || epoch !== '0 || {bram_en, net_start, busy, done, aborted} !== 5'b0) begin
            bad++;
            $display("FAIL rst_async: got addr=%0h ep=%0h ctrl=%b want 0 0 00000",
                     address, epoch, {bram_en, net_start, busy, done, aborted});
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        total++;
        if ({busy, bram_en, net_start} !== 3'b000) begin
            bad++;
            $display("FAIL rst_stays_idle: got %b want 000", {busy, bram_en, net_start});
        end
        take_base();
        start_pulse();
        total++;
        if (address !== '0 || epoch !== '0 || bram_en !== 1'b1) begin
            bad++;
            $display("FAIL rst_restart: got addr=%0h ep=%0h en=%b want 0 0 1", address, epoch, bram_en);
        end
        wait_done(seen);
        repeat (4) @(negedge clk);
        total++;
        if (!seen || ns_total - base_ns !== 8) begin
            bad++;
            $display("FAIL rst_rerun_steps: got done=%b steps=%0d want 1 8", seen, ns_total - base_ns);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        inj_done = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        test_idle_net_done();
        test_first_timing();
        test_full_run();
        test_abort();
        test_start_while_busy();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
